// File: rtl/fp16_acc_seq.sv
// Run sequencer for one fp16_acc instance: streams cfg_len operands into the
// accumulator, waits out its pipeline, captures the sum and clears it for the next run.
module fp16_acc_seq #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ACC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  output logic             busy,
  input  logic             op_valid,
  input  logic [15:0]      op_data,
  output logic             op_ready,
  output logic [15:0]      acc_in_a,
  output logic             acc_accum_done,
  input  logic [15:0]      acc_out_sum,
  output logic             res_valid,
  output logic [15:0]      res_data,
  input  logic             res_ready
);

  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_CLEAR,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] drain_q, drain_d;
  logic             aborted_q, aborted_d;
  logic             busy_q, busy_d;
  logic             op_ready_q, op_ready_d;
  logic             acc_accum_done_q, acc_accum_done_d;
  logic             res_valid_q, res_valid_d;
  logic [DW-1:0]    acc_in_a_q, acc_in_a_d;
  logic [DW-1:0]    res_data_q, res_data_d;
  logic             accept_c;

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    aborted_d  = aborted_q;
    res_data_d = res_data_q;
    acc_in_a_d = '0;
    accept_c   = op_valid & op_ready_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (cfg_len != '0) begin
            len_d   = cfg_len;
            cnt_d   = '0;
            state_d = S_FEED;
          end else begin
            res_data_d = '0;
            state_d    = S_HOLD;
          end
        end
      end
      S_FEED: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_CLEAR;
        end else if (accept_c) begin
          acc_in_a_d = op_data;
          cnt_d      = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Sum is final ACC_LAT cycles after the last operand sits on acc_in_a
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_CLEAR;
        end else if (drain_q == LEN_W'(ACC_LAT)) begin
          res_data_d = acc_out_sum;
          state_d    = S_CLEAR;
        end else begin
          drain_d = drain_q + LEN_W'(1);
        end
      end
      S_CLEAR: begin
        aborted_d = 1'b0;
        state_d   = aborted_q ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (abort || res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d           = (state_d != S_IDLE);
    op_ready_d       = (state_d == S_FEED);
    acc_accum_done_d = (state_d == S_CLEAR);
    res_valid_d      = (state_d == S_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      len_q            <= '0;
      cnt_q            <= '0;
      drain_q          <= '0;
      aborted_q        <= 1'b0;
      busy_q           <= 1'b0;
      op_ready_q       <= 1'b0;
      acc_accum_done_q <= 1'b0;
      res_valid_q      <= 1'b0;
      acc_in_a_q       <= '0;
      res_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      cnt_q            <= cnt_d;
      drain_q          <= drain_d;
      aborted_q        <= aborted_d;
      busy_q           <= busy_d;
      op_ready_q       <= op_ready_d;
      acc_accum_done_q <= acc_accum_done_d;
      res_valid_q      <= res_valid_d;
      acc_in_a_q       <= acc_in_a_d;
      res_data_q       <= res_data_d;
    end
  end

  assign busy           = busy_q;
  assign op_ready       = op_ready_q;
  assign acc_in_a       = acc_in_a_q;
  assign acc_accum_done = acc_accum_done_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;

endmodule

// File: tb/tb_fp16_acc_seq.sv
// Scoreboard bench for fp16_acc_seq: an integer-valued fp16 accumulator model
// sits behind the DUT and expected sums are computed from the accepted operands.
module tb_fp16_acc_seq;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned ACC_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             abort = 1'b0;
  logic             op_valid = 1'b0;
  logic [15:0]      op_data = '0;
  logic             res_ready = 1'b0;
  logic             busy, op_ready, acc_accum_done, res_valid;
  logic [15:0]      acc_in_a, acc_out_sum, res_data;

  fp16_acc_seq #(.LEN_W(LEN_W), .ACC_LAT(ACC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .abort(abort),
    .busy(busy), .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .acc_in_a(acc_in_a), .acc_accum_done(acc_accum_done), .acc_out_sum(acc_out_sum),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  int          n_clear = 0;
  int          n_beats = 0;
  logic [15:0] exp_a = '0;
  logic [15:0] sb_q[$];
  logic [15:0] run_ops[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] int_to_fp16(input int v);
    int   m;
    int   e;
    logic sgn;
    if (v == 0) return 16'h0000;
    sgn = (v < 0);
    m   = (v < 0) ? -v : v;
    e   = 0;
    while ((m >> (e + 1)) != 0) e++;
    return {sgn, 5'(e + 15), 10'((m << (10 - e)) & 'h3FF)};
  endfunction

  function automatic int fp16_to_int(input logic [15:0] h);
    int e;
    int m;
    int v;
    if (h[14:0] == 15'h0) return 0;
    e = int'(h[14:10]) - 15;
    m = int'({1'b1, h[9:0]});
    v = (e >= 10) ? (m << (e - 10)) : (m >> (10 - e));
    return h[15] ? -v : v;
  endfunction

  // Accumulator model: running sum, ACC_LAT cycles from acc_in_a to acc_out_sum
  int          psum;
  logic [15:0] pipe [ACC_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum <= 0;
      for (int i = 0; i < ACC_LAT; i++) pipe[i] <= 16'h0000;
    end else begin
      psum    <= acc_accum_done ? 0 : psum + fp16_to_int(acc_in_a);
      pipe[0] <= int_to_fp16(acc_accum_done ? 0 : psum + fp16_to_int(acc_in_a));
      for (int i = 1; i < ACC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign acc_out_sum = pipe[ACC_LAT-1];

  // Monitor: operand forwarding, event counts, result scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a = 16'h0000;
    end else begin
      check("acc_in_a", acc_in_a, exp_a);
      exp_a = (op_valid && op_ready && !abort) ? op_data : 16'h0000;
      if (acc_accum_done) n_clear++;
      if (op_valid && op_ready) n_beats++;
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL res_unexpected: got %0h expected no result", res_data);
        end else begin
          check("res_data", res_data, sb_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_op_ready"}, op_ready, 0);
    check({tag, "_accum_done"}, acc_accum_done, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_acc_in_a"}, acc_in_a, 16'h0000);
    check({tag, "_res_data"}, res_data, 16'h0000);
  endtask

  // gap_mode: 0 back-to-back, 1 alternating, 2 random gaps
  task automatic run(input int len, input int gap_mode, input int hold_dly,
                     input int abort_at, input bit hold_abort);
    int k = 0;
    int sum = 0;
    int budget = 0;
    int held = 0;
    bit aborted = 0;
    bit habort_done = 0;
    bit v;
    n_clear = 0;
    n_beats = 0;
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (len == 0) begin
      check("len0_res_valid", res_valid, 1);
      sb_q.push_back(16'h0000);
    end
    while (len > 0 && k < len && budget < 2000 && !aborted) begin
      if (abort_at >= 0 && k == abort_at) begin
        abort    = 1'b1;
        op_valid = 1'b0;
        step();
        abort   = 1'b0;
        aborted = 1;
      end else begin
        v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (budget % 2 == 0) : ($urandom_range(0, 2) != 0);
        op_valid = v;
        op_data  = run_ops[k];
        if (v && op_ready) begin
          sum += fp16_to_int(run_ops[k]);
          k++;
        end
        step();
        budget++;
      end
    end
    op_valid = 1'b0;
    if (budget >= 2000) begin
      compared++;
      mismatched++;
      $display("FAIL feed_timeout: got %0d beats expected %0d", k, len);
    end
    if (len > 0 && !aborted) sb_q.push_back(int_to_fp16(sum));
    budget = 0;
    while ((busy || res_valid) && budget < 500) begin
      start = 1'b0;
      abort = 1'b0;
      if (res_valid) begin
        check("hold_op_ready", op_ready, 0);
        if (sb_q.size() != 0) check("hold_res_data", res_data, sb_q[0]);
        if (hold_abort && !habort_done) begin
          abort       = 1'b1;
          res_ready   = 1'b0;
          habort_done = 1;
          void'(sb_q.pop_front());
        end else if (held >= hold_dly) begin
          res_ready = 1'b1;
        end else begin
          if (hold_dly >= 10 && held == 5) start = 1'b1;
          held++;
        end
      end
      step();
      budget++;
    end
    start     = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;
    check("idle_reached", busy, 0);
    check("res_valid_low", res_valid, 0);
    check("clear_pulses", n_clear, (len == 0) ? 0 : 1);
    check("accepted_beats", n_beats, aborted ? abort_at : len);
  endtask

  task automatic fill_random(input int len, input int lo, input int hi);
    run_ops.delete();
    for (int i = 0; i < len; i++)
      run_ops.push_back(int_to_fp16(int'($urandom_range(0, hi - lo)) + lo));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    run_ops = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    run(4, 0, 0, -1, 0);
    run_ops = '{16'h3C00, 16'h4000, 16'hC000};
    run(3, 1, 0, -1, 0);
    run(0, 0, 1, -1, 0);
    fill_random(5, -8, 8);
    run(5, 0, 0, 2, 0);
    run_ops = '{16'h3C00, 16'h3C00};
    run(2, 0, 0, -1, 0);
    fill_random(3, -8, 8);
    run(3, 2, 12, -1, 0);
    fill_random(2, -8, 8);
    run(2, 0, 0, -1, 1);
    fill_random(255, 0, 8);
    run(255, 2, 1, -1, 0);

    for (int r = 0; r < 25; r++) begin
      int len;
      int ab;
      len = int'($urandom_range(0, 12));
      ab  = (len > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      fill_random(len, -8, 8);
      run(len, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ab, 1'b0);
    end

    // Asynchronous reset in the middle of a feed
    fill_random(6, 1, 8);
    start   = 1'b1;
    cfg_len = LEN_W'(6);
    step();
    start    = 1'b0;
    op_valid = 1'b1;
    op_data  = run_ops[0];
    step();
    op_data = run_ops[1];
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    op_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    run_ops = '{16'h4000, 16'h4000, 16'h3C00};
    run(3, 0, 0, -1, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
